// File: rtl/card_shoe_dealer.sv
// Multi-deck card shoe: seed-driven shuffle (seed mod N by serial remainder),
// then deals one card per request in a fixed-stride permuted order.
module card_shoe_dealer #(
  parameter int unsigned DECKS          = 1,
  parameter int unsigned STRIDE         = 5,
  parameter int unsigned CUT_LEFT       = 13,
  parameter bit          AUTO_RESHUFFLE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        shuffle_i,
  input  logic [15:0] seed_i,
  input  logic        request_card_i,
  output logic        card_valid_o,
  output logic [7:0]  card_o,
  output logic [3:0]  card_value_o,
  output logic [8:0]  cards_left_o,
  output logic        shoe_empty_o,
  output logic        cut_reached_o,
  output logic        busy_o
);

  localparam int unsigned N     = 52 * DECKS;
  localparam int unsigned IDX_W = 9;
  localparam int unsigned SUM_W = 10;
  localparam int unsigned SEED_W = 16;
  localparam int unsigned BIT_W = 4;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_SHUFFLE = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]  rem_q, rem_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  left_q, left_d;
  logic              valid_q, valid_d;
  logic [7:0]        card_q, card_d;
  logic [3:0]        value_q, value_d;

  logic [SUM_W-1:0]  rem_trial_c;
  logic [IDX_W-1:0]  rem_next_c;
  logic [SUM_W-1:0]  idx_sum_c;
  logic [IDX_W-1:0]  idx_step_c;
  logic [IDX_W-1:0]  pos_c;
  logic [IDX_W-1:0]  rank0_c;
  logic [1:0]        suit_c;
  logic [3:0]        rank_c;
  logic [3:0]        value_c;

  // Card identity of the current idx: fold into one deck, then split suit/rank.
  always_comb begin
    pos_c = idx_q;
    for (int i = 0; i < 8; i++) begin
      if (pos_c >= IDX_W'(52)) pos_c = pos_c - IDX_W'(52);
    end
    if (pos_c < IDX_W'(13)) begin
      suit_c  = 2'd0;
      rank0_c = pos_c;
    end else if (pos_c < IDX_W'(26)) begin
      suit_c  = 2'd1;
      rank0_c = pos_c - IDX_W'(13);
    end else if (pos_c < IDX_W'(39)) begin
      suit_c  = 2'd2;
      rank0_c = pos_c - IDX_W'(26);
    end else begin
      suit_c  = 2'd3;
      rank0_c = pos_c - IDX_W'(39);
    end
    rank_c  = 4'(rank0_c + IDX_W'(1));
    value_c = (rank_c > 4'd10) ? 4'd10 : rank_c;
  end

  // Datapath steps: one restoring-remainder bit, and the modular stride advance.
  always_comb begin
    rem_trial_c = {rem_q, seed_q[bit_q]};
    rem_next_c  = (rem_trial_c >= SUM_W'(N)) ? IDX_W'(rem_trial_c - SUM_W'(N))
                                             : IDX_W'(rem_trial_c);
    idx_sum_c   = {1'b0, idx_q} + SUM_W'(STRIDE);
    idx_step_c  = (idx_sum_c >= SUM_W'(N)) ? IDX_W'(idx_sum_c - SUM_W'(N))
                                           : IDX_W'(idx_sum_c);
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    left_d  = left_q;
    valid_d = 1'b0;
    card_d  = card_q;
    value_d = value_q;

    case (state_q)
      ST_EMPTY: begin
        if (shuffle_i) begin
          state_d = ST_SHUFFLE;
          seed_d  = seed_i;
          bit_d   = BIT_W'(SEED_W - 1);
          rem_d   = '0;
        end
      end
      ST_SHUFFLE: begin
        rem_d = rem_next_c;
        bit_d = bit_q - BIT_W'(1);
        if (bit_q == '0) begin
          state_d = ST_READY;
          idx_d   = rem_next_c;
          left_d  = IDX_W'(N);
        end
      end
      ST_READY: begin
        if (shuffle_i) begin
          // A new shoe takes priority over a same-cycle request.
          state_d = ST_SHUFFLE;
          seed_d  = seed_i;
          bit_d   = BIT_W'(SEED_W - 1);
          rem_d   = '0;
        end else if (request_card_i) begin
          valid_d = 1'b1;
          card_d  = {2'b00, suit_c, rank_c};
          value_d = value_c;
          idx_d   = idx_step_c;
          left_d  = left_q - IDX_W'(1);
          if (left_q == IDX_W'(1)) begin
            if (AUTO_RESHUFFLE) begin
              state_d = ST_SHUFFLE;
              seed_d  = seed_q + SEED_W'(1);
              bit_d   = BIT_W'(SEED_W - 1);
              rem_d   = '0;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      seed_q  <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
      card_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      card_q  <= card_d;
      value_q <= value_d;
    end
  end

  assign card_valid_o  = valid_q;
  assign card_o        = card_q;
  assign card_value_o  = value_q;
  assign cards_left_o  = left_q;
  assign shoe_empty_o  = (left_q == '0);
  assign cut_reached_o = (left_q != '0) && (left_q <= IDX_W'(CUT_LEFT));
  assign busy_o        = (state_q == ST_SHUFFLE);

endmodule

// File: tb/tb_card_shoe_dealer.sv
// Directed bench for card_shoe_dealer: single-deck instance and a two-deck
// auto-reshuffle instance sharing clock and reset.
module tb_card_shoe_dealer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        shuf1 = 1'b0, req1 = 1'b0;
  logic [15:0] seed1 = '0;
  logic        valid1, empty1, cut1, busy1;
  logic [7:0]  card1;
  logic [3:0]  value1;
  logic [8:0]  left1;

  logic        shuf2 = 1'b0, req2 = 1'b0;
  logic [15:0] seed2 = '0;
  logic        valid2, empty2, cut2, busy2;
  logic [7:0]  card2;
  logic [3:0]  value2;
  logic [8:0]  left2;

  card_shoe_dealer #(.DECKS(1), .STRIDE(5), .CUT_LEFT(13), .AUTO_RESHUFFLE(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .shuffle_i(shuf1), .seed_i(seed1), .request_card_i(req1),
    .card_valid_o(valid1), .card_o(card1), .card_value_o(value1), .cards_left_o(left1),
    .shoe_empty_o(empty1), .cut_reached_o(cut1), .busy_o(busy1));

  card_shoe_dealer #(.DECKS(2), .STRIDE(5), .CUT_LEFT(13), .AUTO_RESHUFFLE(1'b1)) dut2 (
    .clk_i(clk), .rst_i(rst), .shuffle_i(shuf2), .seed_i(seed2), .request_card_i(req2),
    .card_valid_o(valid2), .card_o(card2), .card_value_o(value2), .cards_left_o(left2),
    .shoe_empty_o(empty2), .cut_reached_o(cut2), .busy_o(busy2));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  c0;
    logic [3:0]  v0;
    logic [7:0]  c1;
    logic [3:0]  v1;
  } shuf_vec_t;

  shuf_vec_t tbl[5];
  int seen1[64];
  int seen2[64];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_value(input logic [7:0] c);
    return (c[3:0] > 4'd10) ? 10 : int'(c[3:0]);
  endfunction

  // Count cycles busy stays high, bounded so a stuck DUT cannot hang the run.
  task automatic count_busy(input int which, output int cnt);
    cnt = 0;
    while (((which == 1) ? busy1 : busy2) && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  task automatic shuffle1(input logic [15:0] s, input string name);
    int cnt;
    shuf1 = 1'b1; seed1 = s;
    tick();
    shuf1 = 1'b0;
    count_busy(1, cnt);
    check({name, " busy cycles"}, cnt, 16);
    check({name, " cards_left"}, int'(left1), 52);
  endtask

  task automatic request1(input logic [7:0] c, input logic [3:0] v, input string name);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check({name, " valid"}, int'(valid1), 1);
    check({name, " card"}, int'(card1), int'(c));
    check({name, " value"}, int'(value1), int'(v));
  endtask

  initial begin
    int cnt;
    int ok;
    tbl[0] = '{16'd0,     8'h01, 4'd1,  8'h06, 4'd6};
    tbl[1] = '{16'd100,   8'h3A, 4'd10, 8'h02, 4'd2};
    tbl[2] = '{16'd52,    8'h01, 4'd1,  8'h06, 4'd6};
    tbl[3] = '{16'd65535, 8'h13, 4'd3,  8'h18, 4'd8};
    tbl[4] = '{16'd11,    8'h0C, 4'd10, 8'h14, 4'd4};

    // Reset values
    #12;
    check("rst valid", int'(valid1), 0);
    check("rst card", int'(card1), 0);
    check("rst value", int'(value1), 0);
    check("rst left", int'(left1), 0);
    check("rst empty", int'(empty1), 1);
    check("rst cut", int'(cut1), 0);
    check("rst busy", int'(busy1), 0);
    rst = 1'b0;
    tick();

    // Requests in EMPTY are ignored
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1;
      tick();
      check("empty req valid", int'(valid1), 0);
    end
    req1 = 1'b0;
    check("empty req left", int'(left1), 0);
    check("empty req empty", int'(empty1), 1);

    // Seed 0: first three cards, then card holds
    shuffle1(16'd0, "seed0");
    request1(8'h01, 4'd1, "seed0 c0");
    request1(8'h06, 4'd6, "seed0 c1");
    request1(8'h0B, 4'd10, "seed0 c2");
    check("seed0 left", int'(left1), 49);
    tick();
    check("hold valid", int'(valid1), 0);
    check("hold card", int'(card1), 8'h0B);

    // Table of seeds: each reshuffled from READY
    foreach (tbl[i]) begin
      shuffle1(tbl[i].seed, $sformatf("tbl%0d", i));
      request1(tbl[i].c0, tbl[i].v0, $sformatf("tbl%0d c0", i));
      request1(tbl[i].c1, tbl[i].v1, $sformatf("tbl%0d c1", i));
      check($sformatf("tbl%0d left", i), int'(left1), 50);
    end

    // Deal a whole single-deck shoe back-to-back
    shuffle1(16'd0, "full");
    foreach (seen1[i]) seen1[i] = 0;
    req1 = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      check("full valid", int'(valid1), 1);
      check("full value", int'(value1), exp_value(card1));
      check("full left", int'(left1), 51 - k);
      check("full cut", int'(cut1), ((51 - k) <= 13 && (51 - k) > 0) ? 1 : 0);
      seen1[card1[5:0]]++;
    end
    check("full empty", int'(empty1), 1);
    check("full busy", int'(busy1), 0);
    tick();
    check("full 53rd valid", int'(valid1), 0);
    req1 = 1'b0;
    ok = 0;
    for (int s = 0; s < 4; s++)
      for (int r = 1; r <= 13; r++)
        if (seen1[s * 16 + r] == 1) ok++;
    check("full unique codes", ok, 52);

    // Two decks with auto reshuffle
    shuf2 = 1'b1; seed2 = 16'd7;
    tick();
    shuf2 = 1'b0;
    count_busy(2, cnt);
    check("auto busy cycles", cnt, 16);
    check("auto left", int'(left2), 104);
    foreach (seen2[i]) seen2[i] = 0;
    req2 = 1'b1;
    for (int k = 0; k < 104; k++) begin
      tick();
      check("auto valid", int'(valid2), 1);
      check("auto value", int'(value2), exp_value(card2));
      seen2[card2[5:0]]++;
    end
    req2 = 1'b0;
    check("auto end left", int'(left2), 0);
    check("auto end empty", int'(empty2), 1);
    ok = 0;
    for (int s = 0; s < 4; s++)
      for (int r = 1; r <= 13; r++)
        if (seen2[s * 16 + r] == 2) ok++;
    check("auto each code twice", ok, 52);
    count_busy(2, cnt);
    check("auto reshuffle busy", cnt, 16);
    check("auto reshuffle left", int'(left2), 104);
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    check("auto new first valid", int'(valid2), 1);
    check("auto new first card", int'(card2), 8'h09);
    check("auto new first value", int'(value2), 9);

    // Shuffle and request together in READY: shuffle wins
    shuffle1(16'd3, "both");
    request1(8'h04, 4'd4, "both c0");
    shuf1 = 1'b1; req1 = 1'b1; seed1 = 16'd9;
    tick();
    shuf1 = 1'b0; req1 = 1'b0;
    check("both valid", int'(valid1), 0);
    check("both busy", int'(busy1), 1);
    check("both left", int'(left1), 51);

    // Asynchronous reset in the middle of a shuffle
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst busy", int'(busy1), 0);
    check("arst card", int'(card1), 0);
    check("arst value", int'(value1), 0);
    check("arst left", int'(left1), 0);
    check("arst empty", int'(empty1), 1);
    check("arst valid", int'(valid1), 0);
    #1 rst = 1'b0;
    tick();
    check("arst stays empty", int'(busy1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
